// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: multi-cycle WIDTH-bit add/subtract built from one
// SLICE-bit carry-lookahead slice, processed least-significant slice first.
// The carry between slices is held in a register.
// Optional early exit: define CLA_SERIAL_EARLY_DONE_EN to finish as soon as
// the remaining operand bits and the carry are all zero.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] xa_q, yb_q, acc_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, xs_q, ys_q;
  logic             cout_q, ovf_q, zero_q, in_ready_q, out_valid_q;

  logic [SLICE:0]   slice_s;
  logic [WIDTH-1:0] acc_d, fin_res_s;
  logic             last_s, fin_s, fin_cout_s;

  // One lookahead slice: propagate/generate with an explicit carry chain.
  // Returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b,
                                                input logic             cin);
    logic [SLICE-1:0] p, g;
    logic [SLICE:0]   c;
    p    = a | b;
    g    = a & b;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], a ^ b ^ c[SLICE-1:0]};
  endfunction

  // Slice datapath, accumulator shift and the finish decision for this cycle.
  always_comb begin
    slice_s    = cla_slice(xa_q[SLICE-1:0], yb_q[SLICE-1:0], carry_q);
    acc_d      = (acc_q >> SLICE) |
                 (WIDTH'(slice_s[SLICE-1:0]) << (WIDTH - SLICE));
    last_s     = (cnt_q == CNT_W'(N - 1));
    fin_s      = last_s;
    fin_res_s  = acc_d;
    fin_cout_s = slice_s[SLICE];
`ifdef CLA_SERIAL_EARLY_DONE_EN
    // Nothing left to add: right-align the slices already accumulated.
    if ((cnt_q != '0) && (xa_q == '0) && (yb_q == '0) && !carry_q) begin
      fin_s      = 1'b1;
      fin_res_s  = acc_q >> (SLICE * (N - int'(cnt_q)));
      fin_cout_s = 1'b0;
    end else begin
      fin_s      = last_s;
      fin_res_s  = acc_d;
      fin_cout_s = slice_s[SLICE];
    end
`endif
  end

  // Sequencer FSM with all outputs and datapath state registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xa_q        <= '0;
      yb_q        <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xa_q       <= x;
            yb_q       <= sub ? ~y : y;
            carry_q    <= sub;
            xs_q       <= x[WIDTH-1];
            ys_q       <= sub ? ~y[WIDTH-1] : y[WIDTH-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          xa_q    <= xa_q >> SLICE;
          yb_q    <= yb_q >> SLICE;
          acc_q   <= acc_d;
          carry_q <= slice_s[SLICE];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (fin_s) begin
            result_q    <= fin_res_s;
            cout_q      <= fin_cout_s;
            ovf_q       <= (xs_q == ys_q) && (fin_res_s[WIDTH-1] != xs_q);
            zero_q      <= ~|fin_res_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl with the default 64/4 geometry.
module tb_cla_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sub = 1'b0;
  logic [63:0] x = 64'd0;
  logic [63:0] y = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        cout, ovf, zero;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CLA_SERIAL_EARLY_DONE_EN
  localparam int LAT_34 = 3;
  localparam int LAT_F1 = 4;
`else
  localparam int LAT_34 = 17;
  localparam int LAT_F1 = 17;
`endif

  cla_serial_add_ctrl #(.WIDTH(64), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for out_valid after an accept edge; lat counts cycles from T.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Present one request from IDLE (called at a negedge) and wait for the result.
  task automatic issue(input logic s, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
    sub = s; x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
  endtask

  // Consume the result and return to a negedge in IDLE.
  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL rst_result got %h want 0", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {cout, ovf, zero}); end
  endtask

  task automatic test_add_wrap();
    int lat;
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL wrap_latency got %0d want 17", lat); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL wrap_result got %h want 0", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b101) begin n_fail++; $display("FAIL wrap_flags got %b want 101", {cout, ovf, zero}); end
    pop();
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL wrap_pop got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_sub();
    int lat;
    issue(1'b1, 64'd5, 64'd7, lat);
    n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub57_result got %h want fffffffffffffffe", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL sub57_flags got %b want 000", {cout, ovf, zero}); end
    pop();
    issue(1'b1, 64'd7, 64'd5, lat);
    n_checks++; if (result !== 64'd2) begin n_fail++; $display("FAIL sub75_result got %h want 2", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b100) begin n_fail++; $display("FAIL sub75_flags got %b want 100", {cout, ovf, zero}); end
    pop();
  endtask

  task automatic test_overflow();
    int lat;
    issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
    n_checks++; if (result !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovfadd_result got %h want 8000000000000000", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b010) begin n_fail++; $display("FAIL ovfadd_flags got %b want 010", {cout, ovf, zero}); end
    pop();
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd1, lat);
    n_checks++; if (result !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ovfsub_result got %h want 7fffffffffffffff", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b110) begin n_fail++; $display("FAIL ovfsub_flags got %b want 110", {cout, ovf, zero}); end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(1'b0, 64'd10, 64'd20, lat);
    n_checks++; if (result !== 64'd30) begin n_fail++; $display("FAIL bp_first_result got %h want 1e", result); end
    sub = 1'b0; x = 64'd100; y = 64'd200; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_hs[%0d] got %b want 10", i, {out_valid, in_ready}); end
      n_checks++; if (result !== 64'd30) begin n_fail++; $display("FAIL bp_hold_result[%0d] got %h want 1e", i, result); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_idle got %b want 10", {in_ready, out_valid}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL bp_second_latency got %0d want 17", lat); end
    n_checks++; if (result !== 64'd300) begin n_fail++; $display("FAIL bp_second_result got %h want 12c", result); end
    pop();
  endtask

  task automatic test_reset_midrun();
    int lat;
    sub = 1'b0; x = 64'd1000; y = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL run_hs got %b want 00", {out_valid, in_ready}); end
    n_checks++; if (result !== 64'd300) begin n_fail++; $display("FAIL run_result_held got %h want 12c", result); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL async_rst_hs got %b want 01", {out_valid, in_ready}); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL async_rst_result got %h want 0", result); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 64'd1, 64'd1, lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL post_rst_latency got %0d want 17", lat); end
    n_checks++; if (result !== 64'd2) begin n_fail++; $display("FAIL post_rst_result got %h want 2", result); end
    pop();
  endtask

  task automatic test_early_done();
    int lat;
    issue(1'b0, 64'd3, 64'd4, lat);
    n_checks++; if (lat !== LAT_34) begin n_fail++; $display("FAIL early34_latency got %0d want %0d", lat, LAT_34); end
    n_checks++; if (result !== 64'd7) begin n_fail++; $display("FAIL early34_result got %h want 7", result); end
    pop();
    issue(1'b0, 64'hF, 64'd1, lat);
    n_checks++; if (lat !== LAT_F1) begin n_fail++; $display("FAIL earlyF1_latency got %0d want %0d", lat, LAT_F1); end
    n_checks++; if (result !== 64'h10) begin n_fail++; $display("FAIL earlyF1_result got %h want 10", result); end
    n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL earlyF1_flags got %b want 000", {cout, ovf, zero}); end
    pop();
    issue(1'b1, 64'd3, 64'd4, lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL early_sub_latency got %0d want 17", lat); end
    n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL early_sub_result got %h want ffffffffffffffff", result); end
    pop();
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_midrun();
    test_early_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
